// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 size/sign encodings and bridge FSM state encoding
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores, load extraction/extension, misalignment flag
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic is_b, is_h, sgn;
  logic [7:0] b8;
  logic [15:0] h16;
  always_comb begin
    is_b = funct3 == F3_B || funct3 == F3_BU;
    is_h = funct3 == F3_H || funct3 == F3_HU;
    sgn = funct3 == F3_B || funct3 == F3_H;
    b8 = rword[{off, 3'b000} +: 8];
    h16 = off[1] ? rword[31:16] : rword[15:0];
    be = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_lane = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rdata_ext = is_b ? {{24{sgn & b8[7]}}, b8} : is_h ? {{16{sgn & h16[15]}}, h16} : rword;
    misaligned = (is_h && off[0]) || (funct3 == F3_W && off != 2'b00);
  end
endmodule

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: load/store unit bridging the core datapath onto a valid/ready data bus with stall, timeout and fault
module lsu_bus_bridge import lsu_pkg::*; #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3_q, f3_a;
  logic [1:0] off_q, off_a;
  logic to_q, mis, idle, busy, launch, rd_cap, fin, tout;
  logic [3:0] be_a;
  logic [31:0] wd_a, rd_a;
  assign idle = state == S_IDLE;
  assign busy = state == S_REQ || state == S_RESP;
  // after launch the aligner works from the captured size/offset, not the live inputs
  assign f3_a = idle ? funct3 : f3_q;
  assign off_a = idle ? addr[1:0] : off_q;
  lsu_align u_align (
    .funct3    (f3_a),
    .off       (off_a),
    .wdata     (wdata),
    .rword     (bus_rdata),
    .be        (be_a),
    .wdata_lane(wd_a),
    .rdata_ext (rd_a),
    .misaligned(mis)
  );
  always_comb begin
    launch = idle && mem_req && !mis;
    rd_cap = (state == S_REQ && bus_ready && !bus_we && bus_rvalid) || (state == S_RESP && bus_rvalid);
    fin = rd_cap || (state == S_REQ && bus_ready && bus_we);
    tout = busy && cnt == CNT_W'(TIMEOUT - 1) && !fin;
    state_n = idle ? (launch ? S_REQ : S_IDLE)
            : state == S_DONE ? S_IDLE
            : (fin || tout) ? S_DONE
            : (state == S_REQ && bus_ready) ? S_RESP : state;
    stall = mem_req && !mis && state != S_DONE;
    fault = !rst && ((idle && mem_req && mis) || (state == S_DONE && to_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      to_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      bus_valid <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      to_q <= tout;
      if (launch) begin
        bus_valid <= 1'b1;
        bus_we <= mem_we;
        bus_addr <= {addr[31:2], 2'b00};
        bus_be <= be_a;
        bus_wdata <= wd_a;
        f3_q <= funct3;
        off_q <= addr[1:0];
        cnt <= '0;
        rdata <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_REQ && (bus_ready || tout))
        bus_valid <= 1'b0;
      if (rd_cap)
        rdata <= rd_a;
      else if (tout)
        rdata <= '0;
    end
  end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed accesses with a queue scoreboard checked by a negedge monitor
module tb_lsu_bus_bridge;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst, mem_req, mem_we, stall, fault, bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [2:0] funct3;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_be;
  int tests = 0, fails = 0;
  int cfg_rw = 0, cfg_rv = 0;
  bit cfg_never = 0;
  logic [31:0] cfg_word = '0;
  typedef struct {string nm; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_exp_t;
  typedef struct {string nm; bit chk_rd; logic [31:0] rdata; logic fault; int stall;} done_exp_t;
  bus_exp_t bus_q[$];
  done_exp_t done_q[$];

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // bus slave: ready after cfg_rw waiting cycles, read data cfg_rv cycles after acceptance
  initial begin
    int w;
    int rc;
    bit pend;
    w = 0; rc = 0; pend = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ready = 0;
      bus_rvalid = 0;
      if (rst) begin
        w = 0; pend = 0;
      end else if (bus_valid && !cfg_never) begin
        if (w == cfg_rw) begin
          bus_ready = 1;
          w = 0;
          if (!bus_we) begin
            bus_rdata = cfg_word;
            if (cfg_rv == 0) bus_rvalid = 1;
            else begin pend = 1; rc = 0; end
          end
        end else w++;
      end else if (pend) begin
        rc++;
        if (rc == cfg_rv) begin bus_rvalid = 1; pend = 0; end
      end
    end
  end

  // monitor: bus handshakes, request stability, retirement with stall length
  initial begin
    int scnt;
    logic pv, pwe;
    logic [31:0] pa, pw;
    logic [3:0] pb;
    bus_exp_t be_e;
    done_exp_t d_e;
    scnt = 0; pv = 0; pwe = 0; pa = '0; pw = '0; pb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0; pv = 0;
      end else begin
        if (bus_valid && pv) begin
          chk("stable_addr", bus_addr, pa);
          chk("stable_be", {28'd0, bus_be}, {28'd0, pb});
          chk("stable_wdata", bus_wdata, pw);
          chk("stable_we", {31'd0, bus_we}, {31'd0, pwe});
        end
        if (bus_valid && bus_ready) begin
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_bus: got request at %h expected none", bus_addr);
          end else begin
            be_e = bus_q.pop_front();
            chk({be_e.nm, "_bus_addr"}, bus_addr, be_e.addr);
            chk({be_e.nm, "_bus_be"}, {28'd0, bus_be}, {28'd0, be_e.be});
            chk({be_e.nm, "_bus_wdata"}, bus_wdata, be_e.wdata);
            chk({be_e.nm, "_bus_we"}, {31'd0, bus_we}, {31'd0, be_e.we});
          end
        end
        pv = bus_valid && !bus_ready;
        pa = bus_addr; pb = bus_be; pw = bus_wdata; pwe = bus_we;
        if (mem_req && stall) begin
          scnt++;
          chk("fault_in_stall", {31'd0, fault}, 32'd0);
        end else if (mem_req) begin
          if (done_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_retire: got retire expected none");
          end else begin
            d_e = done_q.pop_front();
            chk({d_e.nm, "_stall"}, scnt, d_e.stall);
            chk({d_e.nm, "_fault"}, {31'd0, fault}, {31'd0, d_e.fault});
            if (d_e.chk_rd) chk({d_e.nm, "_rdata"}, rdata, d_e.rdata);
          end
          scnt = 0;
        end
      end
    end
  end

  task automatic access(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int rw, input int rv, input bit never, input bit has_bus,
                        input logic [3:0] ebe, input logic [31:0] ewd, input bit chk_rd,
                        input logic [31:0] erd, input logic efault, input int estall);
    bit done;
    done = 0;
    @(posedge clk); #1;
    cfg_rw = rw; cfg_rv = rv; cfg_never = never; cfg_word = word;
    if (has_bus) bus_q.push_back('{nm, we, {a[31:2], 2'b00}, ewd, ebe});
    done_q.push_back('{nm, chk_rd, erd, efault, estall});
    mem_req = 1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s: got no retire within 60 cycles expected retire", nm);
    end
    @(posedge clk); #1;
    mem_req = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; mem_req = 0; mem_we = 0; funct3 = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1 rst = 0;
    //     name    we  f3     addr          wdata         word          rw rv nv bus be       bus_wdata     chk rdata         flt stall
    access("sw",   1, F3_W,  32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        0, 2);
    access("sb",   1, F3_B,  32'h103, 32'h000000A5, 32'h0,        0, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 0, 32'h0,        0, 2);
    access("sh",   1, F3_H,  32'h102, 32'h1234BEEF, 32'h0,        1, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 0, 32'h0,        0, 3);
    access("lb",   0, F3_B,  32'h102, 32'h0,        32'h12F45678, 0, 0, 0, 1, 4'b0100, 32'h0,        1, 32'hFFFFFFF4, 0, 2);
    access("lbu",  0, F3_BU, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0, 1, 4'b0100, 32'h0,        1, 32'h000000F4, 0, 3);
    access("lhu",  0, F3_HU, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0, 1, 4'b1100, 32'h0,        1, 32'h000012F4, 0, 3);
    access("lh",   0, F3_H,  32'h100, 32'h0,        32'h12F48678, 0, 0, 0, 1, 4'b0011, 32'h0,        1, 32'hFFFF8678, 0, 2);
    access("lw_w", 0, F3_W,  32'h200, 32'h0,        32'hCAFEF00D, 3, 2, 0, 1, 4'b1111, 32'h0,        1, 32'hCAFEF00D, 0, 7);
    access("lh_mis", 0, F3_H, 32'h101, 32'h0,       32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 0);
    access("lw_mis", 0, F3_W, 32'h102, 32'h0,       32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 0);
    access("lb3",  0, F3_B,  32'h107, 32'h0,        32'h80000000, 2, 0, 0, 1, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0, 4);
    access("lw_to", 0, F3_W, 32'h180, 32'h0,        32'h0,        0, 0, 1, 0, 4'b0000, 32'h0,        1, 32'h0,        1, 17);
    @(posedge clk); #1;
    cfg_never = 1; mem_req = 1; mem_we = 0; funct3 = F3_W; addr = 32'h300;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreq_valid", {31'd0, bus_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1; mem_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreq_rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("midreq_rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    rst = 0; cfg_never = 0;
    access("sw2",  1, F3_W,  32'h0,   32'h11223344, 32'h0,        0, 0, 0, 1, 4'b1111, 32'h11223344, 0, 32'h0,        0, 2);
    repeat (3) @(posedge clk);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
